// File: rtl/mem_arbiter_if.sv
// Bundle of port A, port B and shared-memory signals around the two-port memory arbiter.
// Latency: none; this file only declares wires and their directions.
// Backpressure: none; each Req is a level that the requester holds until its Ack.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // Port A (CPU memory path)
  logic              A_Req;
  logic              A_Wr;
  logic [ADDR_W-1:0] A_Addr;
  logic [DATA_W-1:0] A_WData;
  logic              A_Ack;
  logic [DATA_W-1:0] A_RData;
  // Port B (loader / debug path)
  logic              B_Req;
  logic              B_Wr;
  logic [ADDR_W-1:0] B_Addr;
  logic [DATA_W-1:0] B_WData;
  logic              B_Ack;
  logic [DATA_W-1:0] B_RData;
  // Shared memory bus
  logic              Mem_CE;
  logic              Mem_WE;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_WData;
  logic [DATA_W-1:0] Mem_RData;
  // Status
  logic              Busy;
  logic              Owner;

  // Arbiter side
  modport slave (
    input  A_Req, A_Wr, A_Addr, A_WData,
    input  B_Req, B_Wr, B_Addr, B_WData,
    input  Mem_RData,
    output A_Ack, A_RData, B_Ack, B_RData,
    output Mem_CE, Mem_WE, Mem_Addr, Mem_WData,
    output Busy, Owner
  );

  // Requester / memory side
  modport master (
    output A_Req, A_Wr, A_Addr, A_WData,
    output B_Req, B_Wr, B_Addr, B_WData,
    output Mem_RData,
    input  A_Ack, A_RData, B_Ack, B_RData,
    input  Mem_CE, Mem_WE, Mem_Addr, Mem_WData,
    input  Busy, Owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous SRAM/IO bus between port A (CPU) and port B (loader).
// Latency: Req sampled in IDLE -> Ack ACCESS_CYCLES+1 cycles later; back-to-back spacing ACCESS_CYCLES+2.
// Backpressure: Req is a level held until Ack; port inputs are only sampled in IDLE, ignored otherwise.
module mem_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 3   // legal range 1..15, fits the 4-bit access counter
) (
  input  logic         Clk,
  input  logic         Reset_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;

  logic              r_owner;       // port of current / most recent grant, drives Owner
  logic              r_last_owner;  // round-robin pointer; differs from r_owner only out of reset
  logic              r_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;

  logic              w_grant;       // a grant is issued this IDLE cycle
  logic              w_grant_b;     // granted port: 0 = A, 1 = B
  logic              w_capture;     // last access cycle of a read
  logic              w_sel_wr;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  // Next-state, arbitration and read-capture decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant     = 1'b0;
    w_grant_b   = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.A_Req || bus.B_Req) begin
          w_grant = 1'b1;
          // On a tie, the port that did not win last time goes first
          if (bus.A_Req && bus.B_Req) begin
            w_grant_b = ~r_last_owner;
          end else begin
            w_grant_b = bus.B_Req;
          end
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (r_cnt == 4'd0) begin
          w_capture   = ~r_we;
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_DONE: begin
        // Req is deliberately not looked at here; a held Req re-arbitrates in IDLE
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request fields of the granted port
  assign w_sel_wr    = w_grant_b ? bus.B_Wr    : bus.A_Wr;
  assign w_sel_addr  = w_grant_b ? bus.B_Addr  : bus.A_Addr;
  assign w_sel_wdata = w_grant_b ? bus.B_WData : bus.A_WData;

  // State register and access down-counter
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Latch the winner's request so the memory bus stays stable for the whole access
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_we         <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else if (w_grant) begin
      r_owner      <= w_grant_b;
      r_last_owner <= w_grant_b;
      r_we         <= w_sel_wr;
      r_mem_addr   <= w_sel_addr;
      r_mem_wdata  <= w_sel_wdata;
    end
  end

  // Per-port read data; only the owning port's register moves, and only on reads
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else if (w_capture) begin
      if (r_owner) begin
        r_b_rdata <= bus.Mem_RData;
      end else begin
        r_a_rdata <= bus.Mem_RData;
      end
    end
  end

  // Outputs come from registers or decode of registered state only
  assign bus.Mem_CE    = (r_state == ST_ACCESS);
  assign bus.Mem_WE    = (r_state == ST_ACCESS) && r_we;
  assign bus.Mem_Addr  = r_mem_addr;
  assign bus.Mem_WData = r_mem_wdata;
  assign bus.Busy      = (r_state != ST_IDLE);
  assign bus.Owner     = r_owner;
  assign bus.A_Ack     = (r_state == ST_DONE) && !r_owner;
  assign bus.B_Ack     = (r_state == ST_DONE) && r_owner;
  assign bus.A_RData   = r_a_rdata;
  assign bus.B_RData   = r_b_rdata;

endmodule
